// File: rtl/ysyx_22040088_pkg.sv
// Fetch-stage shared types and constants.
// Tags ride alongside in-flight requests; entries feed decode.
package ysyx_22040088_pkg;

  localparam int XLEN   = 64;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            epoch;
  } fetch_tag_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ysyx_22040088_fetch_unit_if.sv
// Fetch-unit bus: imem request/response channels and decode handoff.
// master = fetch unit, slave = memory + decode environment.
interface ysyx_22040088_fetch_unit_if;
  import ysyx_22040088_pkg::*;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_resp_valid;
  logic [INST_W-1:0] imem_resp_data;
  logic              id_valid;
  logic              id_ready;
  logic [XLEN-1:0]   id_pc;
  logic [INST_W-1:0] id_inst;
  logic              redirect;
  logic [XLEN-1:0]   redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    output id_valid, id_pc, id_inst,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    input  id_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    input  id_valid, id_pc, id_inst,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    output id_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/ysyx_22040088_sync_fifo.sv
// Small synchronous FIFO, power-of-2 depth.
// Push on full is accepted when a pop happens the same cycle.
module ysyx_22040088_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  assign empty   = count == '0;
  assign full    = count == CW'(DEPTH);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;

endmodule

// File: rtl/ysyx_22040088_fetch_unit.sv
// Instruction fetch stage: PC, credit-based issue, epoch-tagged
// in-flight tracking and an instruction buffer toward decode.
module ysyx_22040088_fetch_unit
  import ysyx_22040088_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = ysyx_22040088_pkg::RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  ysyx_22040088_fetch_unit_if.master bus
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic            epoch, run, req_held;
  fetch_tag_t      held_tag, cur_tag, tag_head;
  fetch_entry_t    ent_in, ent_head;
  logic [CW-1:0]   inflight, buf_count;
  logic            tag_empty, buf_empty;
  logic            id_fire, redir, credit, present_new;
  logic            req_fire, resp_fire, resp_keep;

  assign id_fire = ~buf_empty & bus.id_ready;
  assign redir   = id_fire & bus.redirect;
  assign credit  = int'(inflight) + int'(buf_count)
                 - int'(id_fire) < BUF_DEPTH;

  // fetch_pc advances when a request is first shown; a stalled
  // request keeps its own addr/epoch so redirects cannot disturb it
  assign present_new = run & ~req_held & credit;
  assign cur_tag     = req_held ? held_tag
                     : fetch_tag_t'{addr: fetch_pc, epoch: epoch};
  assign req_fire    = bus.imem_req_valid & bus.imem_req_ready;

  assign resp_fire = bus.imem_resp_valid & ~tag_empty;
  assign resp_keep = resp_fire & (tag_head.epoch == epoch) & ~redir;
  assign ent_in    = fetch_entry_t'{pc: tag_head.addr,
                                    inst: bus.imem_resp_data};

  assign bus.imem_req_valid = req_held | present_new;
  assign bus.imem_req_addr  = cur_tag.addr;
  assign bus.id_valid       = ~buf_empty;
  assign bus.id_pc          = buf_empty ? '0 : ent_head.pc;
  assign bus.id_inst        = buf_empty ? '0 : ent_head.inst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      epoch    <= 1'b0;
      run      <= 1'b0;
      req_held <= 1'b0;
      held_tag <= '0;
    end else begin
      run <= 1'b1;
      if (present_new) fetch_pc <= fetch_pc + 64'd4;
      if (redir) begin
        fetch_pc <= bus.redirect_pc;
        epoch    <= ~epoch;
      end
      if (present_new & ~bus.imem_req_ready) begin
        req_held <= 1'b1;
        held_tag <= cur_tag;
      end else if (req_fire) begin
        req_held <= 1'b0;
      end
    end
  end

  ysyx_22040088_sync_fifo #(
    .WIDTH ($bits(fetch_tag_t)),
    .DEPTH (BUF_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_fire),
    .pop   (resp_fire),
    .flush (1'b0),
    .din   (cur_tag),
    .dout  (tag_head),
    .count (inflight),
    .empty (tag_empty)
  );

  ysyx_22040088_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (BUF_DEPTH)
  ) u_inst_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (resp_keep),
    .pop   (id_fire),
    .flush (redir),
    .din   (ent_in),
    .dout  (ent_head),
    .count (buf_count),
    .empty (buf_empty)
  );

  always_ff @(posedge clk)
    if (rst)
      assert (!(bus.imem_resp_valid && tag_empty))
        else $error("imem response with nothing in flight");

endmodule

// File: tb/tb_ysyx_22040088_fetch_unit.sv
// Bench for the fetch unit: random memory/decode behaviour checked
// against the architectural instruction stream (program order).
module tb_ysyx_22040088_fetch_unit;
  import ysyx_22040088_pkg::*;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } pend_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_22040088_fetch_unit_if bus();

  ysyx_22040088_fetch_unit #(
    .RESET_PC  (64'h8000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_fire = 0;
  int rr_p, ir_p, rs_p, rd_p;
  logic rst_v;
  logic rd_rand;
  logic [63:0] rd_tgt;
  logic [63:0] model_pc;
  fetch_entry_t exp_q[$];
  pend_t pend[$];
  logic [63:0] acc_log[$];
  logic held_prev = 1'b0;
  logic [63:0] held_addr;

  function automatic logic [31:0] minst(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [63:0] pc);
    fetch_entry_t e;
    e.pc   = pc;
    e.inst = minst(pc);
    exp_q.push_back(e);
  endtask

  // One cycle: drive inputs after the edge, then advance the model
  // if decode consumes an instruction this cycle.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    rst = rst_v;
    bus.imem_req_ready = $urandom_range(99) < rr_p;
    bus.id_ready       = $urandom_range(99) < ir_p;
    bus.redirect       = $urandom_range(99) < rd_p;
    bus.redirect_pc    = rd_rand ?
      {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_3FFC)} : rd_tgt;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    if (pend.size() > 0 && pend[0].due <= cyc
        && $urandom_range(99) < rs_p) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = minst(pend[0].addr);
    end
    #1;
    if (rst_v && bus.id_valid && bus.id_ready) begin
      n_fire++;
      model_pc = bus.redirect ? bus.redirect_pc : model_pc + 64'd4;
      expect_pc(model_pc);
    end
  endtask

  // Memory: in-order, at least one cycle after acceptance.
  always @(negedge clk) begin
    pend_t p;
    if (!rst) begin
      pend.delete();
    end else begin
      if (bus.imem_resp_valid) void'(pend.pop_front());
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        p.addr = bus.imem_req_addr;
        p.due  = cyc + 1;
        pend.push_back(p);
        acc_log.push_back(bus.imem_req_addr);
      end
    end
  end

  // Monitor: request stability and decode-side scoreboard.
  always @(negedge clk) begin
    fetch_entry_t e;
    if (!rst) begin
      held_prev = 1'b0;
    end else begin
      if (held_prev) begin
        check("req_hold_valid", 64'(bus.imem_req_valid), 64'd1);
        check("req_hold_addr", bus.imem_req_addr, held_addr);
      end
      held_prev = bus.imem_req_valid && !bus.imem_req_ready;
      held_addr = bus.imem_req_addr;
      if (bus.id_valid && bus.id_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL id_unexpected: got pc %h, none expected",
                   bus.id_pc);
        end else begin
          e = exp_q.pop_front();
          check("id_pc", bus.id_pc, e.pc);
          check("id_inst", 64'(bus.id_inst), 64'(e.inst));
        end
      end
    end
  end

  task automatic restart_model();
    exp_q.delete();
    model_pc = 64'h8000_0000;
    expect_pc(model_pc);
  endtask

  initial begin
    int first_req, first_id, n_idv, f0;
    logic [63:0] hexp;
    rst = 1'b0;
    rst_v = 1'b0;
    rd_rand = 1'b0;
    rd_tgt = '0;
    rr_p = 0; ir_p = 0; rs_p = 0; rd_p = 0;
    bus.imem_req_ready = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = '0;
    bus.id_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    repeat (3) step();
    check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    check("rst_id_valid", 64'(bus.id_valid), 64'd0);
    check("rst_id_pc", bus.id_pc, 64'd0);
    check("rst_id_inst", 64'(bus.id_inst), 64'd0);

    // Streaming at full rate with latency 1
    restart_model();
    acc_log.delete();
    rst_v = 1'b1;
    rr_p = 100; ir_p = 100; rs_p = 100;
    first_req = -1; first_id = -1; n_idv = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (first_req < 0 && bus.imem_req_valid) first_req = cyc;
      if (first_id < 0 && bus.id_valid) first_id = cyc;
      if (first_id >= 0) n_idv += int'(bus.id_valid);
    end
    check("first_id_latency", 64'(first_id - first_req), 64'd2);
    check("full_rate", 64'(n_idv), 64'(cyc - first_id + 1));
    for (int i = 0; i < 4; i++)
      check("req_addr_seq",
            (i < acc_log.size()) ? acc_log[i] : '1,
            64'h8000_0000 + 64'(4 * i));

    // Decode stall: head frozen, no new requests once full
    ir_p = 0;
    step();
    check("stall_pc_first", bus.id_pc, exp_q[0].pc);
    repeat (4) step();
    check("stall_req_valid", 64'(bus.imem_req_valid), 64'd0);
    check("stall_id_valid", 64'(bus.id_valid), 64'd1);
    check("stall_pc_frozen", bus.id_pc, exp_q[0].pc);
    check("stall_inst_frozen", 64'(bus.id_inst), 64'(exp_q[0].inst));
    ir_p = 100;
    repeat (6) step();

    // Redirect with requests in flight
    rd_tgt = 64'h8000_0100;
    rd_p = 100;
    step();
    check("redir_sampled", 64'(bus.id_valid), 64'd1);
    rd_p = 0;
    step();
    check("redir_next_valid", 64'(bus.imem_req_valid), 64'd1);
    check("redir_next_addr", bus.imem_req_addr, 64'h8000_0100);
    repeat (6) step();

    // Held request across a redirect
    rr_p = 0;
    step();
    hexp = exp_q[0].pc + 64'd8;
    check("held_addr_c1", bus.imem_req_addr, hexp);
    rd_tgt = 64'h8000_0200;
    rd_p = 100;
    step();
    check("held_redir_sampled", 64'(bus.id_valid), 64'd1);
    check("held_addr_c2", bus.imem_req_addr, hexp);
    rd_p = 0;
    step();
    check("held_addr_c3", bus.imem_req_addr, hexp);
    rr_p = 100;
    step();
    check("held_accept_valid", 64'(bus.imem_req_valid), 64'd1);
    check("held_accept_addr", bus.imem_req_addr, hexp);
    step();
    check("post_held_addr", bus.imem_req_addr, 64'h8000_0200);
    repeat (6) step();

    // Redirect while decode is stalled is ignored
    ir_p = 0;
    rd_tgt = 64'h8000_0300;
    rd_p = 100;
    repeat (3) step();
    check("ignored_redir_pc", bus.id_pc, exp_q[0].pc);
    rd_p = 0;
    ir_p = 100;
    repeat (6) step();

    // Reset pulse mid-stream
    ir_p = 0; rr_p = 0; rs_p = 0;
    rst_v = 1'b0;
    step();
    restart_model();
    rst_v = 1'b1;
    step();
    check("mid_rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    check("mid_rst_id_valid", 64'(bus.id_valid), 64'd0);
    check("mid_rst_id_pc", bus.id_pc, 64'd0);
    check("mid_rst_id_inst", 64'(bus.id_inst), 64'd0);
    rr_p = 100; ir_p = 100; rs_p = 100;
    step();
    check("mid_rst_first_valid", 64'(bus.imem_req_valid), 64'd1);
    check("mid_rst_first_addr", bus.imem_req_addr, 64'h8000_0000);

    // Random traffic
    rd_rand = 1'b1;
    rr_p = 70; ir_p = 75; rs_p = 70; rd_p = 10;
    f0 = n_fire;
    repeat (3000) step();
    check("progress", 64'(n_fire - f0 >= 300), 64'd1);

    rd_p = 0;
    rr_p = 100; ir_p = 100; rs_p = 100;
    repeat (20) step();
    @(negedge clk);
    #1;
    check("exp_q_depth", 64'(exp_q.size()), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
